// File: rtl/sdram_stream_reader.sv
// Read-streaming master for the sdram_ctrl acc/ack port.
// Walks base + n*stride (low WRAP_BITS wrap) into a FWFT FIFO.
//
// Ports:
//   sdram_clk, sdram_rst_n      clock, async active-low reset
//   start_i/abort_i             transfer control
//   base_adr_i/stride_i/count_i transfer setup (count 0 = continuous)
//   busy_o/done_o               transfer status
//   sc_*                        sdram_ctrl request port
//   data_o/valid_o/ready_i      output stream
//   level_o                     FIFO occupancy
module sdram_stream_reader #(
    parameter int ADR_WIDTH    = 32,
    parameter int DATA_WIDTH   = 16,
    parameter int FIFO_DEPTH   = 16,
    parameter int STRIDE_WIDTH = 16,
    parameter int LEN_WIDTH    = 16,
    parameter int WRAP_BITS    = 16
) (
    input  logic                      sdram_clk,
    input  logic                      sdram_rst_n,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic [ADR_WIDTH-1:0]      base_adr_i,
    input  logic [STRIDE_WIDTH-1:0]   stride_i,
    input  logic [LEN_WIDTH-1:0]      count_i,
    output logic                      busy_o,
    output logic                      done_o,
    input  logic                      sc_idle_i,
    output logic [ADR_WIDTH-1:0]      sc_adr_o,
    output logic                      sc_acc_o,
    output logic                      sc_we_o,
    output logic [DATA_WIDTH/8-1:0]   sc_sel_o,
    input  logic                      sc_ack_i,
    input  logic [DATA_WIDTH-1:0]     sc_dat_i,
    output logic [DATA_WIDTH-1:0]     data_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [$clog2(FIFO_DEPTH):0] level_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    // Bits of the address that take part in the increment.
    localparam logic [ADR_WIDTH-1:0] WRAP_MASK =
        {ADR_WIDTH{1'b1}} >> (ADR_WIDTH - WRAP_BITS);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;

    state_t                  state_q;
    logic [ADR_WIDTH-1:0]    adr_q;
    logic [ADR_WIDTH-1:0]    adr_d;
    logic [ADR_WIDTH-1:0]    adr_sum;
    logic [ADR_WIDTH-1:0]    sc_adr_q;
    logic [STRIDE_WIDTH-1:0] stride_q;
    logic [LEN_WIDTH-1:0]    cnt_q;
    logic                    abort_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    acc_q;

    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_q;
    logic [PW-1:0]           rd_ptr_q;
    logic [LW-1:0]           level_q;

    logic acked;
    logic kill;
    logic last;
    logic push;
    logic pop;
    logic flush;
    logic fifo_full;

    assign adr_sum   = adr_q + ADR_WIDTH'(stride_q);
    assign adr_d     = (adr_q & ~WRAP_MASK) | (adr_sum & WRAP_MASK);
    assign acked     = (state_q == WAIT_ACK) && sc_ack_i;
    // An abort raised in the ack cycle itself also discards the word.
    assign kill      = abort_q | abort_i;
    assign last      = (cnt_q == LEN_WIDTH'(1));
    assign push      = acked && !kill;
    assign flush     = ((state_q == ISSUE) && abort_i) || (acked && kill);
    assign pop       = (level_q != '0) && ready_i;
    assign fifo_full = (level_q == LW'(FIFO_DEPTH));

    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            state_q  <= IDLE;
            adr_q    <= '0;
            sc_adr_q <= '0;
            stride_q <= '0;
            cnt_q    <= '0;
            abort_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            acc_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        adr_q    <= base_adr_i;
                        stride_q <= stride_i;
                        cnt_q    <= count_i;
                        abort_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (abort_i) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (sc_idle_i && !fifo_full) begin
                        acc_q    <= 1'b1;
                        sc_adr_q <= adr_q;
                        state_q  <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (abort_i) begin
                        abort_q <= 1'b1;
                    end
                    if (sc_ack_i) begin
                        acc_q <= 1'b0;
                        adr_q <= adr_d;
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - LEN_WIDTH'(1);
                        end
                        if (kill) begin
                            abort_q <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else if (last) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            state_q <= ISSUE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge sdram_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sc_dat_i;
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign sc_adr_o = sc_adr_q;
    assign sc_acc_o = acc_q;
    assign sc_we_o  = 1'b0;
    assign sc_sel_o = '1;
    assign data_o   = mem_q[rd_ptr_q];
    assign valid_o  = (level_q != '0);
    assign level_o  = level_q;

endmodule

// File: tb/tb_sdram_stream_reader.sv
// Bench for sdram_stream_reader: controller model, stream monitor,
// directed and randomized transfers against an arithmetic reference.
module tb_sdram_stream_reader;

    localparam int AW = 32;
    localparam int DW = 16;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [AW-1:0] base_adr_i = '0;
    logic [15:0]   stride_i = '0;
    logic [15:0]   count_i = '0;
    logic          busy_o;
    logic          done_o;
    logic          sc_idle_i = 1'b1;
    logic [AW-1:0] sc_adr_o;
    logic          sc_acc_o;
    logic          sc_we_o;
    logic [1:0]    sc_sel_o;
    logic          sc_ack_i = 1'b0;
    logic [DW-1:0] sc_dat_i = '0;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready_i = 1'b1;
    logic [2:0]    level_o;

    sdram_stream_reader #(
        .ADR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD),
        .STRIDE_WIDTH(16), .LEN_WIDTH(16), .WRAP_BITS(16)
    ) dut (
        .sdram_clk(clk), .sdram_rst_n(rst_n),
        .start_i(start_i), .abort_i(abort_i),
        .base_adr_i(base_adr_i), .stride_i(stride_i),
        .count_i(count_i), .busy_o(busy_o), .done_o(done_o),
        .sc_idle_i(sc_idle_i), .sc_adr_o(sc_adr_o),
        .sc_acc_o(sc_acc_o), .sc_we_o(sc_we_o),
        .sc_sel_o(sc_sel_o), .sc_ack_i(sc_ack_i),
        .sc_dat_i(sc_dat_i), .data_o(data_o),
        .valid_o(valid_o), .ready_i(ready_i),
        .level_o(level_o)
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    int            done_cnt = 0;
    int            lat = 3;
    bit            rand_rdy = 1'b0;
    logic [AW-1:0] req_q [$];
    logic [DW-1:0] pop_q [$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: low 16 bits advance by k*stride modulo 2^16.
    function automatic logic [AW-1:0] exp_adr(input logic [AW-1:0] b,
                                              input logic [15:0] s,
                                              input int k);
        logic [15:0] lo;
        lo = b[15:0] + 16'(k * int'(s));
        return {b[31:16], lo};
    endfunction

    // Controller model: acks lat cycles after acc, data = adr[15:0].
    initial begin : ctrl_model
        int            wcnt;
        logic [AW-1:0] hold;
        wcnt = 0;
        hold = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                sc_ack_i = 1'b0;
                wcnt = 0;
            end else if (sc_ack_i) begin
                sc_ack_i = 1'b0;
                chk("acc_drop", sc_acc_o, 0);
            end else if (sc_acc_o) begin
                if (wcnt == 0) begin
                    req_q.push_back(sc_adr_o);
                    hold = sc_adr_o;
                end else begin
                    chk("adr_hold", sc_adr_o, hold);
                end
                wcnt++;
                if (wcnt >= lat) begin
                    sc_ack_i = 1'b1;
                    sc_dat_i = hold[15:0];
                    wcnt = 0;
                end
            end
        end
    end

    initial begin : stream_mon
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (valid_o && ready_i) pop_q.push_back(data_o);
                if (done_o) begin
                    done_cnt++;
                    chk("busy_at_done", busy_o, 0);
                end
            end
        end
    end

    task automatic do_start(input logic [AW-1:0] b, input logic [15:0] s,
                            input logic [15:0] c);
        req_q.delete();
        pop_q.delete();
        done_cnt = 0;
        @(negedge clk);
        base_adr_i = b;
        stride_i = s;
        count_i = c;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int i;
        i = 0;
        while (busy_o && i < max) begin
            @(negedge clk);
            if (rand_rdy) ready_i = 1'($urandom_range(0, 1));
            i++;
        end
        chk("idle", busy_o, 0);
    endtask

    task automatic settle(input int n);
        rand_rdy = 1'b0;
        ready_i = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_adr(input logic [AW-1:0] b, input logic [15:0] s,
                             input int n);
        chk("nreq", req_q.size(), n);
        for (int k = 0; k < n; k++)
            if (k < req_q.size()) chk("adr", req_q[k], exp_adr(b, s, k));
    endtask

    task automatic check_dat(input logic [AW-1:0] b, input logic [15:0] s,
                             input int n);
        logic [AW-1:0] a;
        chk("npop", pop_q.size(), n);
        for (int k = 0; k < n; k++) begin
            a = exp_adr(b, s, k);
            if (k < pop_q.size()) chk("data", pop_q[k], a[15:0]);
        end
    endtask

    initial begin : main
        int            i;
        logic [AW-1:0] b;
        logic [15:0]   s;
        logic [15:0]   c;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_acc", sc_acc_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_level", level_o, 0);
        chk("we", sc_we_o, 0);
        chk("sel", sc_sel_o, 2'b11);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic counted transfer with latency check.
        lat = 3;
        do_start(32'h100, 16'd16, 16'd4);
        chk("lat_busy", busy_o, 1);
        chk("lat_acc0", sc_acc_o, 0);
        @(negedge clk);
        chk("lat_acc1", sc_acc_o, 1);
        wait_idle(200);
        settle(6);
        check_adr(32'h100, 16'd16, 4);
        check_dat(32'h100, 16'd16, 4);
        chk("done1", done_cnt, 1);

        // Controller not idle for 50 cycles.
        sc_idle_i = 1'b0;
        do_start(32'h100, 16'd16, 16'd4);
        repeat (50) @(negedge clk);
        chk("noidle_req", req_q.size(), 0);
        chk("noidle_acc", sc_acc_o, 0);
        sc_idle_i = 1'b1;
        wait_idle(200);
        settle(6);
        check_adr(32'h100, 16'd16, 4);
        check_dat(32'h100, 16'd16, 4);
        chk("done2", done_cnt, 1);

        // Backpressure: FIFO fills, FSM stalls.
        ready_i = 1'b0;
        do_start(32'h4000, 16'd2, 16'd10);
        repeat (60) @(negedge clk);
        chk("bp_req", req_q.size(), FD);
        chk("bp_level", level_o, FD);
        chk("bp_acc", sc_acc_o, 0);
        chk("bp_busy", busy_o, 1);
        ready_i = 1'b1;
        wait_idle(300);
        settle(8);
        check_adr(32'h4000, 16'd2, 10);
        check_dat(32'h4000, 16'd2, 10);
        chk("done3", done_cnt, 1);

        // Low-window wrap; a start while busy must be ignored.
        do_start(32'h0003_FFF0, 16'd16, 16'd3);
        base_adr_i = 32'hDEAD_0000;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_idle(200);
        settle(6);
        check_adr(32'h0003_FFF0, 16'd16, 3);
        check_dat(32'h0003_FFF0, 16'd16, 3);
        chk("done4", done_cnt, 1);

        // Continuous mode, abort during the 6th request.
        lat = 6;
        do_start(32'h800, 16'd4, 16'd0);
        i = 0;
        while (req_q.size() < 6 && i < 300) begin
            @(negedge clk);
            i++;
        end
        chk("ab_req6", req_q.size(), 6);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk("ab_hold", sc_acc_o, 1);
        wait_idle(50);
        settle(6);
        check_adr(32'h800, 16'd4, 6);
        check_dat(32'h800, 16'd4, 5);
        chk("ab_done", done_cnt, 0);
        chk("ab_level", level_o, 0);
        chk("ab_valid", valid_o, 0);

        // Reset in the middle of WAIT_ACK.
        ready_i = 1'b0;
        do_start(32'h200, 16'd4, 16'd5);
        i = 0;
        while (req_q.size() < 2 && i < 300) begin
            @(negedge clk);
            i++;
        end
        @(negedge clk);
        chk("pre_rst_level", level_o, 1);
        rst_n = 1'b0;
        #1;
        chk("mr_acc", sc_acc_o, 0);
        chk("mr_busy", busy_o, 0);
        chk("mr_valid", valid_o, 0);
        chk("mr_level", level_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ready_i = 1'b1;
        lat = 3;
        @(negedge clk);
        do_start(32'h300, 16'd8, 16'd2);
        wait_idle(200);
        settle(6);
        check_adr(32'h300, 16'd8, 2);
        check_dat(32'h300, 16'd8, 2);
        chk("done_mr", done_cnt, 1);

        // Randomized transfers with random ready and ack latency.
        for (int t = 0; t < 12; t++) begin
            b = $urandom;
            s = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            c = 16'($urandom_range(1, 12));
            lat = $urandom_range(1, 4);
            do_start(b, s, c);
            rand_rdy = 1'b1;
            wait_idle(1000);
            settle(8);
            check_adr(b, s, int'(c));
            check_dat(b, s, int'(c));
            chk("done_rand", done_cnt, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
